// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: control inputs from stall controller,
// exception unit and EX, plus the fetch address outputs.
// master = PC generator side, slave = consumer/driver side.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  flush_pc;
    logic               branch_flag;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               pend_valid;
    logic               misalign;

    modport master (
        input  stall, flush, flush_pc, branch_flag, branch_target,
        output pc, ce, pend_valid, misalign
    );

    modport slave (
        output stall, flush, flush_pc, branch_flag, branch_target,
        input  pc, ce, pend_valid, misalign
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// Sequential stepping, flush/branch redirects and a one-entry buffer
// holding a branch that arrives while the PC stage is stalled.
// Optional macro PC_ALIGN_CHECK_EN: redirect targets get bits [1:0]
// cleared and a misaligned raw target raises misalign for one cycle.
module pc_gen #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              STEP      = 4,
    parameter int              STALL_W   = 6
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);
    typedef enum logic {OFF = 1'b0, RUN = 1'b1} state_t;

    // Redirect sources: 0 = flush, 1 = branch, 2 = pending buffer
    localparam int NSRC = 3;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] pend_addr_reg, pend_addr_next;
    logic              pend_valid_reg, pend_valid_next;
    logic              misalign_reg, misalign_next;

    logic [ADDR_W-1:0] redir_raw [NSRC];
    logic [ADDR_W-1:0] redir_tgt [NSRC];
    logic              redir_mis [NSRC];

    logic stall_pc;
    assign stall_pc = bus.stall[0];

    // Only the PC-stage stall bit matters here; upper bits are ignored
    logic unused_stall;
    assign unused_stall = &{1'b0, bus.stall[STALL_W-1:1]};

    assign redir_raw[0] = bus.flush_pc;
    assign redir_raw[1] = bus.branch_target;
    assign redir_raw[2] = pend_addr_reg;

    // Per-source target conditioning; the pending entry keeps the raw
    // address so misalignment is flagged when applied, not when captured
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_redir
`ifdef PC_ALIGN_CHECK_EN
            assign redir_tgt[gi] = {redir_raw[gi][ADDR_W-1:2], 2'b00};
            assign redir_mis[gi] = |redir_raw[gi][1:0];
`else
            assign redir_tgt[gi] = redir_raw[gi];
            assign redir_mis[gi] = 1'b0;
`endif
        end
    endgenerate

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= OFF;
            pc_reg         <= RESET_VEC;
            pend_addr_reg  <= '0;
            pend_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_addr_reg  <= pend_addr_next;
            pend_valid_reg <= pend_valid_next;
            misalign_reg   <= misalign_next;
        end
    end

    // Next-state and PC selection in redirect priority order
    always_comb begin
        state_next      = RUN;
        pc_next         = pc_reg;
        pend_addr_next  = pend_addr_reg;
        pend_valid_next = pend_valid_reg;
        misalign_next   = 1'b0;

        // In OFF the PC holds RESET_VEC so the first enabled fetch uses it
        if (state_reg == RUN) begin
            if (bus.flush) begin
                pc_next         = redir_tgt[0];
                misalign_next   = redir_mis[0];
                pend_valid_next = 1'b0;
            end else if (bus.branch_flag && !stall_pc) begin
                pc_next         = redir_tgt[1];
                misalign_next   = redir_mis[1];
                pend_valid_next = 1'b0;
            end else if (bus.branch_flag && stall_pc) begin
                pend_addr_next  = bus.branch_target;
                pend_valid_next = 1'b1;
            end else if (pend_valid_reg && !stall_pc) begin
                pc_next         = redir_tgt[2];
                misalign_next   = redir_mis[2];
                pend_valid_next = 1'b0;
            end else if (!stall_pc) begin
                pc_next = pc_reg + ADDR_W'(STEP);
            end
        end
    end

    assign bus.pc         = pc_reg;
    assign bus.ce         = (state_reg == RUN);
    assign bus.pend_valid = pend_valid_reg;
    assign bus.misalign   = misalign_reg;
endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen (RESET_VEC = 32'h1000).
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();

    pc_gen #(
        .ADDR_W   (32),
        .RESET_VEC(32'h0000_1000),
        .STEP     (4),
        .STALL_W  (6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
    endtask

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] BR_A   = 32'h0000_2000;
    localparam logic [31:0] BR_A4  = 32'h0000_2004;
    localparam logic [31:0] PEND_A = 32'h0000_3000;
    localparam logic [31:0] MIS1   = 32'd1;
`else
    localparam logic [31:0] BR_A   = 32'h0000_2002;
    localparam logic [31:0] BR_A4  = 32'h0000_2006;
    localparam logic [31:0] PEND_A = 32'h0000_3001;
    localparam logic [31:0] MIS1   = 32'd0;
`endif

    initial begin
        bus.stall         = '0;
        bus.flush         = 1'b0;
        bus.flush_pc      = '0;
        bus.branch_flag   = 1'b0;
        bus.branch_target = '0;

        // Reset held three edges: OFF, ce low, pc at reset vector
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ce", bus.ce, 0);
            check("rst_pc", bus.pc, 32'h1000);
            check("rst_pend", bus.pend_valid, 0);
            check("rst_mis", bus.misalign, 0);
        end
        rst = 1'b0;
        tick();
        check("start_ce", bus.ce, 1);
        check("start_pc", bus.pc, 32'h1000);
        tick();
        check("seq_pc1", bus.pc, 32'h1004);
        tick();
        check("seq_pc2", bus.pc, 32'h1008);

        // Stall hold for two edges
        bus.stall = 6'b000001;
        tick();
        check("stall_pc1", bus.pc, 32'h1008);
        check("stall_ce", bus.ce, 1);
        tick();
        check("stall_pc2", bus.pc, 32'h1008);
        bus.stall = '0;
        tick();
        check("resume_pc", bus.pc, 32'h100C);

        // Branch buffered under stall
        bus.stall = 6'b000001;
        bus.branch_flag = 1'b1;
        bus.branch_target = 32'h2000;
        tick();
        check("buf_pend", bus.pend_valid, 1);
        check("buf_pc", bus.pc, 32'h100C);
        bus.branch_flag = 1'b0;
        bus.stall = '0;
        tick();
        check("buf_apply_pc", bus.pc, 32'h2000);
        check("buf_apply_pend", bus.pend_valid, 0);
        tick();
        check("buf_next_pc", bus.pc, 32'h2004);

        // Flush beats simultaneous branch, stall and pending entry
        bus.stall = 6'b000001;
        bus.branch_flag = 1'b1;
        bus.branch_target = 32'h5000;
        tick();
        check("pre_flush_pend", bus.pend_valid, 1);
        bus.flush = 1'b1;
        bus.flush_pc = 32'h20;
        bus.branch_target = 32'h3000;
        tick();
        check("flush_pc", bus.pc, 32'h20);
        check("flush_pend", bus.pend_valid, 0);
        bus.flush = 1'b0;
        bus.branch_flag = 1'b0;
        bus.stall = '0;
        tick();
        check("post_flush_pc", bus.pc, 32'h24);

        // Upper stall bits do not stall the PC
        bus.stall = 6'b111110;
        tick();
        check("upper_stall_pc", bus.pc, 32'h28);
        bus.stall = '0;

        // Wrap at top of address space
        bus.flush = 1'b1;
        bus.flush_pc = 32'hFFFF_FFFC;
        tick();
        check("wrap_top", bus.pc, 32'hFFFF_FFFC);
        bus.flush = 1'b0;
        tick();
        check("wrap_zero", bus.pc, 32'h0);
        tick();
        check("wrap_four", bus.pc, 32'h4);

        // Misaligned unstalled branch
        bus.branch_flag = 1'b1;
        bus.branch_target = 32'h2002;
        tick();
        check("mis_br_pc", bus.pc, BR_A);
        check("mis_br_flag", bus.misalign, MIS1);
        bus.branch_flag = 1'b0;
        tick();
        check("mis_br_clear", bus.misalign, 0);
        check("mis_br_next", bus.pc, BR_A4);

        // Misaligned branch buffered: flagged on apply, not capture
        bus.stall = 6'b000001;
        bus.branch_flag = 1'b1;
        bus.branch_target = 32'h3001;
        tick();
        check("mis_cap_flag", bus.misalign, 0);
        check("mis_cap_pend", bus.pend_valid, 1);
        bus.branch_flag = 1'b0;
        bus.stall = '0;
        tick();
        check("mis_pend_pc", bus.pc, PEND_A);
        check("mis_pend_flag", bus.misalign, MIS1);

        // Reset while a branch is pending discards it
        bus.stall = 6'b000001;
        bus.branch_flag = 1'b1;
        bus.branch_target = 32'h4000;
        tick();
        check("rst2_pre_pend", bus.pend_valid, 1);
        bus.branch_flag = 1'b0;
        rst = 1'b1;
        tick();
        check("rst2_ce", bus.ce, 0);
        check("rst2_pc", bus.pc, 32'h1000);
        check("rst2_pend", bus.pend_valid, 0);
        rst = 1'b0;
        bus.stall = '0;
        tick();
        check("rst2_start_ce", bus.ce, 1);
        check("rst2_start_pc", bus.pc, 32'h1000);
        tick();
        check("rst2_seq_pc", bus.pc, 32'h1004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage; the next generation of the basic PC register.
- Adds a configurable reset vector, address width and step.
- Adds pipeline flush redirect, branch redirect, and a pending-redirect buffer that holds a branch arriving while fetch is stalled.
- Drives pc and ce to instruction memory / IF-ID; consumes stall from the stall controller, flush from the exception unit and branch from EX.

Parameters:
ADDR_W, 32, PC/target width in bits
RESET_VEC, 32'h0000_0000, first fetch address after reset (ADDR_W bits)
STEP, 4, sequential increment in bytes
STALL_W, 6, width of the stall vector; bit 0 = PC stage

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, synchronous, active-high
stall  input  STALL_W  stall vector; only stall[0] used here, 1 = hold PC
flush  input  1  exception/flush redirect request
flush_pc  input  ADDR_W  flush target (handler/EPC)
branch_flag  input  1  taken branch/jump from EX
branch_target  input  ADDR_W  branch target
pc  output  ADDR_W  current fetch address
ce  output  1  instruction memory chip enable
pend_valid  output  1  a branch redirect is buffered awaiting stall release
misalign  output  1  registered pulse: redirect target misaligned (see Optional Feature)

Behaviour:
- Reset is synchronous, active-high, on clk; clk is the only clock.
- Two-state FSM:
  - OFF: entered while rst=1; ce=0.
  - RUN: entered on the first edge with rst=0; ce=1.
- Reset values: ce=0, pc=RESET_VEC, pend_valid=0, pend_addr=0, misalign=0.
- In OFF, and on the OFF->RUN edge, pc stays RESET_VEC, so the first fetch with ce=1 is at RESET_VEC.
- Per-edge update in RUN, in strict priority order:
  1. flush=1: pc<=flush_pc. Ignores stall[0]. Clears pend_valid. A branch in the same cycle is discarded.
  2. branch_flag=1 and stall[0]=0: pc<=branch_target. Clears pend_valid. Overrides any pending target.
  3. branch_flag=1 and stall[0]=1: pc holds; pend_addr<=branch_target; pend_valid<=1. Overwrites any older pending target.
  4. pend_valid=1 and stall[0]=0: pc<=pend_addr; pend_valid<=0.
  5. stall[0]=0: pc<=pc+STEP, modulo 2^ADDR_W. Max address wraps, e.g. 32'hFFFF_FFFC -> 0.
  6. Otherwise (stall[0]=1): pc, pend state unchanged.
- Latency: a redirect presented at edge N (unstalled) is visible on pc after edge N; 1 cycle. A buffered redirect appears after the first unstalled edge.
- ce stays 1 throughout RUN, including during stall.
- rst=1 mid-operation, including while pend_valid=1: next edge returns to OFF with all reset values; the pending target is lost.
- stall[STALL_W-1:1] are ignored.
- Width rule: STEP is zero-extended to ADDR_W before the add; the carry out is dropped.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined:
  - Any redirect target (flush_pc, branch_target, or pend_addr when taken) is applied with bits [1:0] forced to 0.
  - If the raw target had bits [1:0] != 0, misalign is 1 for exactly the cycle after the redirect edge, else 0.
  - A misaligned branch captured into pend_addr is flagged when applied, not when captured.
- Not defined: targets are used verbatim; misalign tied to 0.

Test Plan:
- Reset/start (RESET_VEC=32'h0000_1000): rst=1 for 3 cycles, then 0 -> ce 0,0,0 then 1; pc=32'h1000 on the first ce=1 cycle, then 32'h1004, 32'h1008.
- Stall hold: in RUN at pc=32'h1008, stall=6'b000001 for 2 cycles -> pc stays 32'h1008 with ce=1; resumes at 32'h100C.
- Branch buffered under stall: stall[0]=1 plus branch_flag=1 with target 32'h2000 for one cycle -> pend_valid=1, pc held; release stall -> pc=32'h2000, pend_valid=0, next pc 32'h2004.
- Flush priority: flush=1 (flush_pc=32'h0000_0020), branch_flag=1 (target 32'h3000) and stall[0]=1 with pend_valid=1 all in the same cycle -> pc=32'h20, pend_valid=0.
- Wrap: flush to 32'hFFFF_FFFC, then unstalled -> pc=32'h0000_0000, then 32'h4.
- PC_ALIGN_CHECK_EN: branch_target=32'h2002 unstalled -> pc=32'h2000, misalign=1 for one cycle; with macro undefined -> pc=32'h2002, misalign=0.
